// File: rtl/stream2fbuf.sv
// stream2fbuf: AXI-stream video into a (double-buffered) framebuffer write port.
module stream2fbuf #(
  parameter int FBUF_WIDTH      = 320,
  parameter int FBUF_HEIGHT     = 240,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int PIXEL_WIDTH     = 24,
  parameter int DOUBLE_BUFFER   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIXEL_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       eof,
  output logic                       fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_waddr,
  output logic [PIXEL_WIDTH-1:0]     fbuf_wdata,
  output logic                       wr_bank,
  output logic                       rd_bank,
  output logic                       frame_done,
  output logic                       err_sof,
  output logic                       err_eol_early,
  output logic                       err_eol_late
);
  localparam int XW = $clog2(FBUF_WIDTH);
  localparam int YW = $clog2(FBUF_HEIGHT);
  localparam logic [FBUF_ADDR_WIDTH-1:0] FRAME = FBUF_ADDR_WIDTH'(FBUF_WIDTH * FBUF_HEIGHT);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LINE  = FBUF_ADDR_WIDTH'(FBUF_WIDTH);
  typedef enum logic [1:0] {WAIT_SOF, WRITE, DROP, WAIT_SWAP} state_t;
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [FBUF_ADDR_WIDTH-1:0] line_addr, base;
  logic eof_q, hs, x_end, y_end, restart, sof;
  assign s_axis_tready = state != WAIT_SWAP;
  assign hs      = s_axis_tvalid && s_axis_tready;
  assign base    = wr_bank ? FRAME : '0;
  assign x_end   = x == XW'(FBUF_WIDTH - 1);
  assign y_end   = y == YW'(FBUF_HEIGHT - 1);
  assign restart = s_axis_tuser && (state == DROP || (state == WRITE && (x != '0 || y != '0)));
  assign sof     = hs && ((state == WAIT_SOF && s_axis_tuser) || restart);
  // line_addr tracks bank base + y*FBUF_WIDTH so no multiplier is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_SOF;
      x             <= '0;
      y             <= '0;
      line_addr     <= '0;
      eof_q         <= 1'b0;
      fbuf_we       <= 1'b0;
      fbuf_waddr    <= '0;
      fbuf_wdata    <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= DOUBLE_BUFFER != 0;
      frame_done    <= 1'b0;
      err_sof       <= 1'b0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
    end else begin
      eof_q         <= eof;
      fbuf_we       <= 1'b0;
      frame_done    <= 1'b0;
      err_sof       <= 1'b0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
      if (sof) begin
        fbuf_we    <= 1'b1;
        fbuf_waddr <= base;
        fbuf_wdata <= s_axis_tdata;
        err_sof    <= restart;
        x          <= XW'(1);
        y          <= '0;
        line_addr  <= base;
        state      <= WRITE;
      end else if (hs && state == WRITE) begin
        fbuf_we    <= 1'b1;
        fbuf_waddr <= line_addr + FBUF_ADDR_WIDTH'(x);
        fbuf_wdata <= s_axis_tdata;
        if (s_axis_tlast) begin
          err_eol_early <= !x_end;
          x             <= '0;
          y             <= y + 1'b1;
          line_addr     <= line_addr + LINE;
          if (y_end) begin
            frame_done <= 1'b1;
            state      <= WAIT_SWAP;
          end
        end else if (x_end) begin
          err_eol_late <= 1'b1;
          state        <= DROP;
        end else begin
          x <= x + 1'b1;
        end
      end else if (hs && state == DROP && s_axis_tlast) begin
        x          <= '0;
        y          <= y + 1'b1;
        line_addr  <= line_addr + LINE;
        frame_done <= y_end;
        state      <= y_end ? WAIT_SWAP : WRITE;
      end else if (state == WAIT_SWAP && (DOUBLE_BUFFER == 0 || (eof && !eof_q && !frame_done))) begin
        // frame_done is high only in the entry cycle, so an edge there is ignored
        state <= WAIT_SOF;
        x     <= '0;
        y     <= '0;
        if (DOUBLE_BUFFER != 0) begin
          rd_bank <= wr_bank;
          wr_bank <= ~wr_bank;
        end
      end
    end
  end
endmodule

// File: tb/tb_stream2fbuf.sv
// tb_stream2fbuf: directed scenario tests for stream2fbuf (4x2 frame, double buffered).
module tb_stream2fbuf;
  logic clk = 0, rst = 1;
  logic [23:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 0, s_axis_tuser = 0, s_axis_tlast = 0, eof = 0;
  logic s_axis_tready, fbuf_we, wr_bank, rd_bank, frame_done, err_sof, err_eol_early, err_eol_late;
  logic [18:0] fbuf_waddr;
  logic [23:0] fbuf_wdata;
  int checks = 0, errors = 0;

  typedef struct {
    logic [23:0] d;
    logic u, l, we;
    int a;
    logic [3:0] f;
  } vec_t;

  always #5 clk = ~clk;

  stream2fbuf #(.FBUF_WIDTH(4), .FBUF_HEIGHT(2), .FBUF_ADDR_WIDTH(19), .PIXEL_WIDTH(24), .DOUBLE_BUFFER(1)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .eof(eof), .fbuf_we(fbuf_we), .fbuf_waddr(fbuf_waddr), .fbuf_wdata(fbuf_wdata),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_done(frame_done), .err_sof(err_sof),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late)
  );

  task automatic beat(input logic [23:0] d, input logic u, input logic l);
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1;
    @(posedge clk); #1;
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    idle(2);
    checks++;
    if (fbuf_we !== 0 || fbuf_waddr !== 0 || fbuf_wdata !== 0 || wr_bank !== 0 || rd_bank !== 1 ||
        {frame_done, err_sof, err_eol_early, err_eol_late} !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%0d data=%h wr=%b rd=%b flags=%b, required 0 0 0 0 1 0000",
               fbuf_we, fbuf_waddr, fbuf_wdata, wr_bank, rd_bank, {frame_done, err_sof, err_eol_early, err_eol_late});
    end
    rst = 0; idle(1);
    checks++;
    if (s_axis_tready !== 1 || fbuf_we !== 0) begin
      errors++; $display("FAIL reset_release: tready=%b we=%b, required 1 0", s_axis_tready, fbuf_we);
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        beat(24'(i + 1 + 16 * f), i == 0, i % 4 == 3);
        checks++;
        if (fbuf_we !== 1 || fbuf_waddr !== 19'(8 * f + i) || fbuf_wdata !== 24'(i + 1 + 16 * f) ||
            {frame_done, err_sof, err_eol_early, err_eol_late} !== (i == 7 ? 4'b1000 : 4'b0000)) begin
          errors++;
          $display("FAIL clean[%0d.%0d]: we=%b addr=%0d data=%h flags=%b, required we=1 addr=%0d data=%h flags=%b",
                   f, i, fbuf_we, fbuf_waddr, fbuf_wdata, {frame_done, err_sof, err_eol_early, err_eol_late},
                   8 * f + i, i + 1 + 16 * f, i == 7 ? 4'b1000 : 4'b0000);
        end
      end
      checks++;
      if (s_axis_tready !== 0) begin errors++; $display("FAIL wait_swap_tready: %b, required 0", s_axis_tready); end
      idle(1);
      eof = 1; idle(1); eof = 0;
      checks++;
      if (wr_bank !== !f[0] || rd_bank !== f[0] || s_axis_tready !== 1) begin
        errors++;
        $display("FAIL swap[%0d]: wr=%b rd=%b tready=%b, required wr=%b rd=%b tready=1", f, wr_bank, rd_bank, s_axis_tready, !f[0], f[0]);
      end
    end
  endtask

  task automatic test_garbage_early;
    vec_t v[8];
    v = '{'{24'hAA, 0, 0, 0, 0, 0}, '{24'hBB, 0, 1, 0, 0, 0}, '{24'h11, 1, 0, 1, 0, 0}, '{24'h12, 0, 1, 1, 1, 2},
          '{24'h13, 0, 0, 1, 4, 0}, '{24'h14, 0, 0, 1, 5, 0}, '{24'h15, 0, 0, 1, 6, 0}, '{24'h16, 0, 1, 1, 7, 8}};
    eof = 1;
    foreach (v[i]) begin
      beat(v[i].d, v[i].u, v[i].l);
      checks++;
      if (fbuf_we !== v[i].we || (v[i].we && (fbuf_waddr !== 19'(v[i].a) || fbuf_wdata !== v[i].d)) ||
          {frame_done, err_sof, err_eol_early, err_eol_late} !== v[i].f) begin
        errors++;
        $display("FAIL garbage[%0d]: we=%b addr=%0d data=%h flags=%b, required we=%b addr=%0d data=%h flags=%b",
                 i, fbuf_we, fbuf_waddr, fbuf_wdata, {frame_done, err_sof, err_eol_early, err_eol_late},
                 v[i].we, v[i].a, v[i].d, v[i].f);
      end
    end
    idle(3);
    checks++;
    if (wr_bank !== 0 || s_axis_tready !== 0) begin
      errors++; $display("FAIL eof_held: wr=%b tready=%b, required 0 0", wr_bank, s_axis_tready);
    end
    eof = 0; idle(1);
    eof = 1; idle(1); eof = 0;
    checks++;
    if (wr_bank !== 1 || rd_bank !== 0 || s_axis_tready !== 1) begin
      errors++; $display("FAIL eof_reedge: wr=%b rd=%b tready=%b, required 1 0 1", wr_bank, rd_bank, s_axis_tready);
    end
  endtask

  task automatic test_reset_midframe;
    beat(24'h31, 1, 0);
    beat(24'h32, 0, 0);
    checks++;
    if (fbuf_we !== 1 || fbuf_waddr !== 9 || fbuf_wdata !== 24'h32) begin
      errors++; $display("FAIL bank1_write: we=%b addr=%0d data=%h, required 1 9 32", fbuf_we, fbuf_waddr, fbuf_wdata);
    end
    s_axis_tdata = 24'h33; s_axis_tvalid = 1; s_axis_tuser = 0;
    rst = 1; #1;
    checks++;
    if (fbuf_we !== 0 || fbuf_waddr !== 0 || fbuf_wdata !== 0 || wr_bank !== 0 || rd_bank !== 1) begin
      errors++;
      $display("FAIL reset_mid: we=%b addr=%0d data=%h wr=%b rd=%b, required 0 0 0 0 1", fbuf_we, fbuf_waddr, fbuf_wdata, wr_bank, rd_bank);
    end
    idle(2);
    rst = 0; idle(1);
    s_axis_tvalid = 0;
    checks++;
    if (fbuf_we !== 0 || s_axis_tready !== 1) begin
      errors++; $display("FAIL after_release: we=%b tready=%b, required 0 1", fbuf_we, s_axis_tready);
    end
    beat(24'h34, 1, 0);
    checks++;
    if (fbuf_we !== 1 || fbuf_waddr !== 0 || fbuf_wdata !== 24'h34) begin
      errors++; $display("FAIL restart_after_reset: we=%b addr=%0d data=%h, required 1 0 34", fbuf_we, fbuf_waddr, fbuf_wdata);
    end
    rst = 1; idle(1); rst = 0; idle(1);
  endtask

  task automatic test_late_sof;
    vec_t v[15];
    v = '{'{24'h21, 1, 0, 1, 0, 0}, '{24'h22, 0, 0, 1, 1, 0}, '{24'h23, 0, 0, 1, 2, 0}, '{24'h24, 0, 0, 1, 3, 1},
          '{24'h25, 0, 0, 0, 0, 0}, '{24'h26, 0, 1, 0, 0, 0}, '{24'h27, 0, 0, 1, 4, 0}, '{24'h28, 1, 0, 1, 0, 4},
          '{24'h29, 0, 0, 1, 1, 0}, '{24'h2A, 0, 0, 1, 2, 0}, '{24'h2B, 0, 1, 1, 3, 0}, '{24'h2C, 0, 0, 1, 4, 0},
          '{24'h2D, 0, 0, 1, 5, 0}, '{24'h2E, 0, 0, 1, 6, 0}, '{24'h2F, 0, 1, 1, 7, 8}};
    foreach (v[i]) begin
      beat(v[i].d, v[i].u, v[i].l);
      checks++;
      if (fbuf_we !== v[i].we || (v[i].we && (fbuf_waddr !== 19'(v[i].a) || fbuf_wdata !== v[i].d)) ||
          {frame_done, err_sof, err_eol_early, err_eol_late} !== v[i].f) begin
        errors++;
        $display("FAIL late_sof[%0d]: we=%b addr=%0d data=%h flags=%b, required we=%b addr=%0d data=%h flags=%b",
                 i, fbuf_we, fbuf_waddr, fbuf_wdata, {frame_done, err_sof, err_eol_early, err_eol_late},
                 v[i].we, v[i].a, v[i].d, v[i].f);
      end
    end
    eof = 1; idle(1);
    checks++;
    if (wr_bank !== 0 || s_axis_tready !== 0) begin
      errors++; $display("FAIL eof_in_done_cycle: wr=%b tready=%b, required 0 0", wr_bank, s_axis_tready);
    end
    idle(1); eof = 0; idle(1);
    eof = 1; idle(1); eof = 0;
    checks++;
    if (wr_bank !== 1 || rd_bank !== 0) begin
      errors++; $display("FAIL late_swap: wr=%b rd=%b, required 1 0", wr_bank, rd_bank);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_garbage_early;
    test_reset_midframe;
    test_late_sof;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream2fbuf.md
STREAM2FBUF -- requirements
Module: stream2fbuf

Interface
REQ-001 SHALL have parameters (name, default, meaning): FBUF_WIDTH, 320, stored pixels per line (>=2) | FBUF_HEIGHT, 240, stored lines per frame (>=2) | FBUF_ADDR_WIDTH, 19, write address width | PIXEL_WIDTH, 24, pixel data width | DOUBLE_BUFFER, 1, 1 = two banks with swap, 0 = single bank.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk in 1: sole clock; all logic rising-edge.
- rst in 1: reset; asynchronous, active-high.
- s_axis_tdata in PIXEL_WIDTH: pixel.
- s_axis_tvalid in 1: beat valid.
- s_axis_tready out 1: beat accepted when tvalid & tready.
- s_axis_tuser in 1: start of frame (first pixel).
- s_axis_tlast in 1: end of line (last pixel).
- eof in 1: vertical-blanking level from the display timing generator, same clk.
- fbuf_we out 1: framebuffer write enable.
- fbuf_waddr out FBUF_ADDR_WIDTH: write address.
- fbuf_wdata out PIXEL_WIDTH: write data.
- wr_bank out 1: bank being written.
- rd_bank out 1: bank the display reads; used as the read-address MSB/offset.
- frame_done out 1: one-cycle pulse, frame fully received.
- err_sof out 1: one-cycle pulse, early SOF.
- err_eol_early out 1: one-cycle pulse, tlast before x = FBUF_WIDTH-1.
- err_eol_late out 1: one-cycle pulse, no tlast at x = FBUF_WIDTH-1.

Function
REQ-003 SHALL define FRAME_SIZE = FBUF_WIDTH*FBUF_HEIGHT; write address SHALL be wr_bank*FRAME_SIZE + y*FBUF_WIDTH + x, generated by incrementing counters (no runtime multiplier), truncated to FBUF_ADDR_WIDTH.
REQ-004 SHALL implement states WAIT_SOF, WRITE, DROP, WAIT_SWAP.
REQ-005 s_axis_tready SHALL be 1 in WAIT_SOF, WRITE, DROP and 0 in WAIT_SWAP, decoded from state only (no dependence on tvalid).
REQ-006 WAIT_SOF: accepted beats with tuser=0 SHALL be discarded silently; an accepted beat with tuser=1 SHALL be written at (0,0), x becomes 1, go WRITE.
REQ-007 WRITE: each accepted beat SHALL be written at (x,y) and increment x.
REQ-008 WRITE, accepted tlast=1 at x = FBUF_WIDTH-1: normal end of line; x<=0, y<=y+1.
REQ-009 WRITE, accepted tlast=1 at x < FBUF_WIDTH-1: beat written, err_eol_early pulses, x<=0, y<=y+1; remaining pixels of that line left unwritten.
REQ-010 WRITE, accepted beat at x = FBUF_WIDTH-1 with tlast=0: beat written, err_eol_late pulses, go DROP; DROP SHALL discard beats until an accepted tlast=1 (also discarded), then x<=0, y<=y+1, return WRITE (or WAIT_SWAP per REQ-012).
REQ-011 Accepted tuser=1 in WRITE or DROP at any position other than (0,0) in WRITE: err_sof pulses, beat written at (0,0), x<=1, y<=0, state WRITE; error checks of REQ-009/010 SHALL not also fire for that beat.
REQ-012 Completion of line FBUF_HEIGHT-1 (REQ-008/009/010) SHALL pulse frame_done and enter WAIT_SWAP.
REQ-013 WAIT_SWAP, DOUBLE_BUFFER=1: on an eof rising edge (eof=1, registered eof=0) detected while in WAIT_SWAP: rd_bank<=wr_bank, wr_bank<=~wr_bank, go WAIT_SOF; an edge in the cycle of entry into WAIT_SWAP or earlier SHALL NOT count.
REQ-014 WAIT_SWAP, DOUBLE_BUFFER=0: go WAIT_SOF next cycle; wr_bank and rd_bank SHALL stay 0.
REQ-015 fbuf_we/fbuf_waddr/fbuf_wdata SHALL be registered: 1 cycle after handshake; fbuf_we=0 for discarded beats; error/frame_done pulses aligned with that write cycle.
REQ-016 Back-to-back beats every cycle SHALL be sustained without bubbles in WAIT_SOF/WRITE/DROP.

Reset
REQ-017 Reset SHALL force: state WAIT_SOF, x=y=0, fbuf_we=0, fbuf_waddr=0, fbuf_wdata=0, all pulses 0, registered eof=0, wr_bank=0, rd_bank=DOUBLE_BUFFER; s_axis_tready=1 after release.
REQ-018 Reset mid-frame SHALL abandon the frame; no write SHALL be issued in the cycle after release.

Verification (FBUF_WIDTH=4, FBUF_HEIGHT=2, DOUBLE_BUFFER=1)
REQ-019 Clean frame, 8 beats data 1..8, tuser on first, tlast on 4th/8th -> writes addr 0..7 data 1..8, frame_done with write 7, tready=0 until eof rises, then wr_bank=1, rd_bank=0; next frame writes addr 8..15.
REQ-020 Two garbage beats before SOF -> no fbuf_we for them; SOF beat written at addr 0.
REQ-021 tlast on 2nd beat of line 0 -> err_eol_early, next beat written at addr 4.
REQ-022 Line 0 of 6 beats, tlast on 6th -> err_eol_late at addr 3 write, beats 5-6 not written, next beat at addr 4.
REQ-023 tuser on beat at addr 5 -> err_sof, beat written at addr 0 (current bank), frame restarts.
REQ-024 eof held high through frame end, or rising in the frame_done cycle -> no swap until next eof rising edge; rst asserted mid-line -> outputs per REQ-017 immediately.
